// File: rtl/instr_loader.sv
// Boot-time loader: encodes decoded MIPS commands into 32-bit words and writes
// them to consecutive instruction-memory words, holding the CPU until done.
module instr_loader #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_kind,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_rd,
  input  logic [15:0]       cmd_imm,
  input  logic [25:0]       cmd_target,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W+1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {S_LOAD, S_WRITE, S_DONE, S_ERROR} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W:0]     word_count_q, word_count_d;
  logic [ADDR_W+1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                last_q, last_d;
  logic [31:0]         enc_word;
  logic                enc_legal;
  logic                accept;
  logic                full;

  always_comb begin
    enc_word  = 32'h0;
    enc_legal = 1'b1;
    case (cmd_kind)
      4'd0:  enc_word = 32'h0;
      4'd1:  enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100001};
      4'd2:  enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100011};
      4'd3:  enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100100};
      4'd4:  enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b100101};
      4'd5:  enc_word = {6'b000000, cmd_rs, cmd_rt, cmd_rd, 5'b00000, 6'b101011};
      4'd6:  enc_word = {6'b100011, cmd_rs, cmd_rt, cmd_imm};
      4'd7:  enc_word = {6'b101011, cmd_rs, cmd_rt, cmd_imm};
      4'd8:  enc_word = {6'b000100, cmd_rs, cmd_rt, cmd_imm};
      4'd9:  enc_word = {6'b000101, cmd_rs, cmd_rt, cmd_imm};
      4'd10: enc_word = {6'b000010, cmd_target};
      default: enc_legal = 1'b0;
    endcase
  end

  // The top count bit is only ever set once every memory word has been written.
  assign full   = word_count_q[ADDR_W];
  assign accept = (state_q == S_LOAD) && cmd_valid;

  always_comb begin
    state_d      = state_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    last_d       = last_q;
    case (state_q)
      S_LOAD: begin
        if (accept) begin
          if (!enc_legal || full) begin
            state_d = S_ERROR;
          end else begin
            addr_d  = {word_count_q[ADDR_W-1:0], 2'b00};
            wdata_d = enc_word;
            last_d  = cmd_last;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        word_count_d = word_count_q + 1'b1;
        state_d      = last_q ? S_DONE : S_LOAD;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_LOAD;
      word_count_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      last_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      last_q       <= last_d;
    end
  end

  // Gating with rst cancels a write whose WRITE cycle coincides with reset.
  assign imem_we    = (state_q == S_WRITE) && !rst;
  assign cmd_ready  = (state_q == S_LOAD);
  assign cpu_hold   = (state_q != S_DONE);
  assign done       = (state_q == S_DONE);
  assign err        = (state_q == S_ERROR);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign word_count = word_count_q;

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader: encoding table plus back-to-back, error,
// reset-during-write and overflow sequences.
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, o_valid;
  logic [3:0]  cmd_kind;
  logic [4:0]  cmd_rs, cmd_rt, cmd_rd;
  logic [15:0] cmd_imm;
  logic [25:0] cmd_target;
  logic        cmd_last;

  logic        cmd_ready, imem_we, cpu_hold, done, err;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [8:0]  word_count;

  logic        o_ready, o_we, o_hold, o_done, o_err;
  logic [3:0]  o_addr;
  logic [31:0] o_wdata;
  logic [2:0]  o_count;

  int pass_cnt = 0;
  int total_cnt = 0;
  int we_seen;

  always #5 clk = ~clk;

  instr_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err), .word_count(word_count)
  );

  instr_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .cmd_valid(o_valid), .cmd_ready(o_ready),
    .cmd_kind(cmd_kind), .cmd_rs(cmd_rs), .cmd_rt(cmd_rt), .cmd_rd(cmd_rd),
    .cmd_imm(cmd_imm), .cmd_target(cmd_target), .cmd_last(cmd_last),
    .imem_we(o_we), .imem_addr(o_addr), .imem_wdata(o_wdata),
    .cpu_hold(o_hold), .done(o_done), .err(o_err), .word_count(o_count)
  );

  typedef struct {
    logic [3:0]  kind;
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [25:0] target;
    logic [31:0] exp_word;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else
      pass_cnt++;
  endtask

  task automatic set_cmd(input vec_t v);
    cmd_kind = v.kind; cmd_rs = v.rs; cmd_rt = v.rt; cmd_rd = v.rd;
    cmd_imm = v.imm; cmd_target = v.target;
  endtask

  task automatic scramble();
    cmd_kind = 4'($urandom_range(0, 10)); cmd_rs = 5'($urandom);
    cmd_rt = 5'($urandom); cmd_rd = 5'($urandom);
    cmd_imm = 16'($urandom); cmd_target = 26'($urandom);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; cmd_valid = 1'b0; o_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{4'd1,  5'd1,  5'd2,  5'd3, 16'hABCD, 26'h3FFFFFF, 32'h00221821};
    vecs[1]  = '{4'd6,  5'd0,  5'd8,  5'd0, 16'h0004, 26'h0,       32'h8C080004};
    vecs[2]  = '{4'd8,  5'd1,  5'd2,  5'd0, 16'hFFFF, 26'h0,       32'h1022FFFF};
    vecs[3]  = '{4'd9,  5'd1,  5'd2,  5'd0, 16'hFFFF, 26'h0,       32'h1422FFFF};
    vecs[4]  = '{4'd10, 5'd31, 5'd31, 5'd31, 16'h1234, 26'h10,     32'h08000010};
    vecs[5]  = '{4'd0,  5'd7,  5'd9,  5'd11, 16'h5555, 26'h2AAAAAA, 32'h00000000};
    vecs[6]  = '{4'd2,  5'd4,  5'd5,  5'd6, 16'h0,    26'h0,       32'h00853023};
    vecs[7]  = '{4'd3,  5'd7,  5'd8,  5'd9, 16'h0,    26'h0,       32'h00E84824};
    vecs[8]  = '{4'd4,  5'd1,  5'd1,  5'd1, 16'h0,    26'h0,       32'h00210825};
    vecs[9]  = '{4'd5,  5'd2,  5'd3,  5'd4, 16'hFFFF, 26'h0,       32'h0043202B};
    vecs[10] = '{4'd7,  5'd29, 5'd31, 5'd0, 16'h0010, 26'h0,       32'hAFBF0010};

    rst = 1'b1; cmd_valid = 1'b0; o_valid = 1'b0; cmd_last = 1'b0;
    cmd_kind = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0; cmd_imm = '0; cmd_target = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_ready", cmd_ready, 1); chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);  chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", cpu_hold, 1);   chk("rst_done", done, 0);
    chk("rst_err", err, 0);         chk("rst_count", word_count, 0);
    $display("reset checked");

    // Encoding table, one command at a time with idle gaps
    for (int i = 0; i < 11; i++) begin
      set_cmd(vecs[i]);
      cmd_last = (i == 10);
      cmd_valid = 1'b1;
      chk("tbl_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      scramble();
      chk("tbl_we", imem_we, 1);
      chk("tbl_ready_wr", cmd_ready, 0);
      chk("tbl_addr", imem_addr, 64'(i * 4));
      chk("tbl_wdata", imem_wdata, vecs[i].exp_word);
      $display("vec %0d kind=%0d addr=0x%03h wdata=0x%08h", i, vecs[i].kind, imem_addr, imem_wdata);
      @(negedge clk);
      chk("tbl_we_off", imem_we, 0);
      chk("tbl_count", word_count, 64'(i + 1));
      chk("tbl_addr_hold", imem_addr, 64'(i * 4));
      chk("tbl_wdata_hold", imem_wdata, vecs[i].exp_word);
      chk("tbl_done", done, (i == 10));
      chk("tbl_hold", cpu_hold, (i != 10));
    end
    cmd_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("done_stays", done, 1); chk("done_no_we", imem_we, 0);
    chk("done_count", word_count, 11); chk("done_ready", cmd_ready, 0);
    cmd_valid = 1'b0;

    // Back-to-back with cmd_valid held high
    do_reset();
    cmd_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("b2b_ready", cmd_ready, (c % 2 == 0));
      chk("b2b_we", imem_we, (c % 2 == 1));
      if (c % 2 == 0) begin
        set_cmd(vecs[c / 2 + 6]);
        cmd_last = (c == 6);
      end else begin
        chk("b2b_addr", imem_addr, 64'((c / 2) * 4));
        chk("b2b_wdata", imem_wdata, vecs[c / 2 + 6].exp_word);
        $display("b2b write addr=0x%03h wdata=0x%08h", imem_addr, imem_wdata);
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    chk("b2b_done", done, 1); chk("b2b_count", word_count, 4);

    // Illegal kind as first command, then recovery through reset
    do_reset();
    cmd_kind = 4'd12; cmd_last = 1'b1; cmd_valid = 1'b1;
    we_seen = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("ill_err", err, 1); chk("ill_ready", cmd_ready, 0);
    chk("ill_hold", cpu_hold, 1); chk("ill_done", done, 0);
    for (int c = 0; c < 4; c++) begin
      if (imem_we) we_seen++;
      @(negedge clk);
    end
    chk("ill_no_we", 64'(we_seen), 0); chk("ill_count", word_count, 0);
    $display("illegal kind: err=%0d done=%0d", err, done);
    do_reset();
    chk("rec_err", err, 0); chk("rec_ready", cmd_ready, 1); chk("rec_count", word_count, 0);
    set_cmd(vecs[0]); cmd_last = 1'b0; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("rec_we", imem_we, 1); chk("rec_addr", imem_addr, 0);
    chk("rec_wdata", imem_wdata, 32'h00221821);

    // Reset asserted during the WRITE cycle
    do_reset();
    set_cmd(vecs[2]); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstw_we", imem_we, 0);
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_count", word_count, 0); chk("rstw_ready", cmd_ready, 1);
    chk("rstw_addr", imem_addr, 0); chk("rstw_wdata", imem_wdata, 0);
    $display("reset during write: count=%0d ready=%0d", word_count, cmd_ready);

    // Overflow on the 4-word instance
    do_reset();
    we_seen = 0;
    cmd_last = 1'b0;
    for (int k = 0; k < 4; k++) begin
      set_cmd(vecs[k]);
      o_valid = 1'b1;
      @(negedge clk);
      o_valid = 1'b0;
      chk("ovf_we", o_we, 1);
      chk("ovf_addr", o_addr, 64'(k * 4));
      chk("ovf_wdata", o_wdata, vecs[k].exp_word);
      @(negedge clk);
    end
    chk("ovf_count4", o_count, 4); chk("ovf_ready4", o_ready, 1); chk("ovf_err_pre", o_err, 0);
    set_cmd(vecs[4]); cmd_last = 1'b1; o_valid = 1'b1;
    @(negedge clk);
    o_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (o_we) we_seen++;
      @(negedge clk);
    end
    chk("ovf_err", o_err, 1); chk("ovf_no_we", 64'(we_seen), 0);
    chk("ovf_count", o_count, 4); chk("ovf_done", o_done, 0); chk("ovf_hold", o_hold, 1);
    $display("overflow: err=%0d count=%0d", o_err, o_count);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
# instr_loader

Boot-time instruction encoder and loader for the MIPS pipeline. Accepts instructions in decoded form (kind plus register and immediate fields) over a valid/ready command port. Encodes each into a 32-bit MIPS word using the same opcode/func assignments the pipeline controller decodes, and writes it to consecutive instruction-memory words. Holds the CPU in reset until the program is fully loaded.

## Interface
- ADDR_W, 8, instruction-memory depth is 2^ADDR_W words
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  loader can accept a command this cycle
- cmd_kind  in  4  0 nop, 1 add, 2 sub, 3 and, 4 or, 5 slt, 6 lw, 7 sw, 8 beq, 9 bne, 10 j; 11–15 illegal
- cmd_rs, cmd_rt, cmd_rd  in  5 each  register fields
- cmd_imm  in  16  immediate / branch offset
- cmd_target  in  26  jump target field
- cmd_last  in  1  this command is the final program word
- imem_we  out  1  instruction-memory write strobe
- imem_addr  out  ADDR_W+2  byte address; always {word_idx, 2'b00}
- imem_wdata  out  32  encoded instruction
- cpu_hold  out  1  holds the CPU in reset while loading
- done  out  1  program fully loaded
- err  out  1  sticky error: illegal kind or overflow
- word_count  out  ADDR_W+1  words written so far

## Operation
- Encoding, opcode [31:26]:
  - R-type: {000000, rs, rt, rd, 00000, func}; func values are add 100001, sub 100011, and 100100, or 100101, slt 101011.
  - nop: 32'h0; all fields are ignored.
  - lw: {100011, rs, rt, imm}
  - sw: {101011, rs, rt, imm}
  - beq: {000100, rs, rt, imm}
  - bne: {000101, rs, rt, imm}
  - j: {000010, target}
  - Fields not used by a kind are ignored.
- State machine:
  - LOAD: cmd_ready=1. Acceptance occurs when cmd_valid & cmd_ready.
    - On acceptance of a legal kind with word_count < 2^ADDR_W: register the encoded word and cmd_last, then go to WRITE.
    - Illegal kind: set err, go to ERROR. Nothing is written.
    - Acceptance when word_count == 2^ADDR_W: set err, go to ERROR. Nothing is written.
  - WRITE: cmd_ready=0. imem_we=1 for exactly this cycle, with imem_addr = word_count*4 and imem_wdata = registered word. At the end of the cycle word_count increments. Next state is DONE if the registered last bit is set, otherwise LOAD.
  - DONE: cmd_ready=0, done=1, cpu_hold=0. Remains here until rst.
  - ERROR: cmd_ready=0, err=1, cpu_hold=1, done=0. Remains here until rst.
- cpu_hold=1 in every state except DONE.
- imem_addr and imem_wdata hold their last values when imem_we=0.
- word_count never wraps. After the 2^ADDR_W-th write it reads 2^ADDR_W; the next acceptance is the overflow error.

## Timing
- Reset values: state LOAD, cmd_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, err=0, word_count=0.
- Latency: a command accepted in cycle N is written (imem_we=1) in cycle N+1.
- Throughput: one word per 2 cycles; cmd_ready drops for the WRITE cycle.
- done rises in cycle N+2 after acceptance of the last command in cycle N. cpu_hold falls in the same cycle.
- cmd_last on an illegal or overflowing command is ignored; the block goes to ERROR.
- cmd_valid deasserted in LOAD: the block idles indefinitely with no writes.
- rst asserted in any state, including the WRITE cycle: imem_we=0 in that cycle, and all reset values apply next cycle. A write pending at reset is not performed.
- Command fields are sampled only on the acceptance cycle.

## Test plan
- add rs=1 rt=2 rd=3, last=0 → write 0x00221821 at addr 0x000. Then lw rs=0 rt=8 imm=4, last=1 → write 0x8C080004 at addr 0x004. done=1 two cycles after the lw acceptance; word_count=2.
- beq rs=1 rt=2 imm=0xFFFF → 0x1022FFFF. bne with the same fields → 0x1422FFFF. j target=0x10 → 0x08000010. nop with nonzero fields → 0x00000000.
- cmd_valid held high continuously across 4 commands → cmd_ready alternates 1,0. Writes land at 0x0, 0x4, 0x8, 0xC on alternating cycles, with no command lost or duplicated.
- cmd_kind=12 as the first command → no imem_we, err=1, cmd_ready=0, cpu_hold=1, done=0. rst → all reset values restored and loading resumes at addr 0.
- ADDR_W=2: 4 commands with last=0 → 4 writes and word_count=4. A 5th command → err=1 and no write.
- Assert rst in a WRITE cycle → imem_we=0 that cycle. Next cycle word_count=0 and cmd_ready=1.
